// File: rtl/led_fade_ctrl.sv
// led_fade_ctrl: fade scheduler for a bank of pwm channels.
// Fade commands (led, target, step) arrive over valid/ready. Once per fade
// tick, a single shared add/compare path visits each channel in turn and
// moves its duty one step toward the target.
module led_fade_ctrl #(
    parameter int N_LEDS           = 4,
    parameter int BRIGHTNESS_WIDTH = 8,
    parameter int TICK_DIV         = 100000
) (
    input  logic                                          sysclk,
    input  logic                                          rst,
    input  logic                                          i_cmd_valid,
    output logic                                          o_cmd_ready,
    input  logic [((N_LEDS > 1) ? $clog2(N_LEDS) : 1)-1:0] i_cmd_led,
    input  logic [BRIGHTNESS_WIDTH-1:0]                   i_cmd_target,
    input  logic [BRIGHTNESS_WIDTH-1:0]                   i_cmd_step,
    output logic [N_LEDS*BRIGHTNESS_WIDTH-1:0]            o_duty,
    output logic [N_LEDS-1:0]                             o_enb,
    output logic [N_LEDS-1:0]                             o_busy,
    output logic [N_LEDS-1:0]                             o_done,
    output logic                                          o_err
);

    localparam int BW    = BRIGHTNESS_WIDTH;
    localparam int LED_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [LED_W:0]   N_LEDS_V = (LED_W + 1)'(N_LEDS);
    localparam logic [LED_W-1:0] LAST_IDX = LED_W'(N_LEDS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t            state_r, state_n;
    logic [LED_W-1:0]  idx_r, idx_n;
    logic [CNT_W-1:0]  cnt_r;
    logic              ready_r;
    logic              err_r;

    logic [BW-1:0]     duty_r [N_LEDS];
    logic [BW-1:0]     tgt_r  [N_LEDS];
    logic [BW-1:0]     step_r [N_LEDS];
    logic [N_LEDS-1:0] busy_r;
    logic [N_LEDS-1:0] enb_r;
    logic [N_LEDS-1:0] done_r;

    logic [BW-1:0]     duty_n [N_LEDS];
    logic [BW-1:0]     tgt_n  [N_LEDS];
    logic [BW-1:0]     step_n [N_LEDS];
    logic [N_LEDS-1:0] busy_n;
    logic [N_LEDS-1:0] enb_n;
    logic [N_LEDS-1:0] done_n;

    logic              tick_s;
    logic              acc_s;
    logic              led_ok_s;
    logic              scan_s;

    // Channel currently visited by the shared step unit.
    logic [BW-1:0]     cur_d_s, cur_t_s, cur_s_s;
    logic [BW:0]       gap_up_s, gap_dn_s;
    logic [BW-1:0]     stepped_s;
    logic              lands_s;

    assign tick_s   = (cnt_r == CNT_LAST);
    assign acc_s    = i_cmd_valid && ready_r;
    assign led_ok_s = ({1'b0, i_cmd_led} < N_LEDS_V);
    assign scan_s   = (state_r == ST_SCAN);

    assign o_cmd_ready = ready_r;
    assign o_enb       = enb_r;
    assign o_busy      = busy_r;
    assign o_done      = done_r;
    assign o_err       = err_r;

    for (genvar g = 0; g < N_LEDS; g++) begin : g_duty_out
        assign o_duty[g*BW +: BW] = duty_r[g];
    end

    // Free-running fade tick divider.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (tick_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Scheduler next-state: idle until a tick, then visit each channel once.
    always_comb begin
        state_n = state_r;
        idx_n   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (tick_s) begin
                    state_n = ST_SCAN;
                    idx_n   = {LED_W{1'b0}};
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (idx_r == LAST_IDX) begin
                    state_n = ST_IDLE;
                    idx_n   = {LED_W{1'b0}};
                end else begin
                    idx_n = idx_r + {{(LED_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_n = ST_IDLE;
                idx_n   = {LED_W{1'b0}};
            end
        endcase
    end

    // Scheduler state, scan index and the registered ready/err flags.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= {LED_W{1'b0}};
            ready_r <= 1'b1;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            idx_r   <= idx_n;
            ready_r <= (state_n == ST_IDLE);
            err_r   <= acc_s && !led_ok_s;
        end
    end

    // Shared step unit: one bounded move toward target, never past it.
    always_comb begin
        cur_d_s   = duty_r[idx_r];
        cur_t_s   = tgt_r[idx_r];
        cur_s_s   = step_r[idx_r];
        gap_up_s  = {1'b0, cur_t_s} - {1'b0, cur_d_s};
        gap_dn_s  = {1'b0, cur_d_s} - {1'b0, cur_t_s};
        stepped_s = cur_d_s;
        lands_s   = 1'b0;
        if (cur_d_s < cur_t_s) begin
            if (gap_up_s <= {1'b0, cur_s_s}) begin
                stepped_s = cur_t_s;
                lands_s   = 1'b1;
            end else begin
                stepped_s = cur_d_s + cur_s_s;
            end
        end else if (cur_d_s > cur_t_s) begin
            if (gap_dn_s <= {1'b0, cur_s_s}) begin
                stepped_s = cur_t_s;
                lands_s   = 1'b1;
            end else begin
                stepped_s = cur_d_s - cur_s_s;
            end
        end else begin
            stepped_s = cur_d_s;
            lands_s   = 1'b0;
        end
    end

    // Per-channel next values: command write in IDLE, scan step in SCAN.
    always_comb begin
        for (int i = 0; i < N_LEDS; i++) begin
            duty_n[i] = duty_r[i];
            tgt_n[i]  = tgt_r[i];
            step_n[i] = step_r[i];
            busy_n[i] = busy_r[i];
            done_n[i] = 1'b0;
            if (acc_s && led_ok_s && (i_cmd_led == LED_W'(i))) begin
                tgt_n[i]  = i_cmd_target;
                step_n[i] = i_cmd_step;
                if (i_cmd_step == {BW{1'b0}}) begin
                    duty_n[i] = i_cmd_target;
                    busy_n[i] = 1'b0;
                end else begin
                    busy_n[i] = (duty_r[i] != i_cmd_target);
                end
            end else if (scan_s && (idx_r == LED_W'(i))) begin
                duty_n[i] = stepped_s;
                if (lands_s) begin
                    busy_n[i] = 1'b0;
                    done_n[i] = 1'b1;
                end else begin
                    busy_n[i] = busy_r[i];
                end
            end else begin
                duty_n[i] = duty_r[i];
            end
            // Enable lags busy by one cycle so a fade to 0 keeps the pwm
            // running for the cycle in which it lands.
            enb_n[i] = (duty_n[i] != {BW{1'b0}}) || busy_r[i];
        end
    end

    // Per-channel duty/target/step/status registers.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_LEDS; i++) begin
                duty_r[i] <= {BW{1'b0}};
                tgt_r[i]  <= {BW{1'b0}};
                step_r[i] <= {BW{1'b0}};
            end
            busy_r <= {N_LEDS{1'b0}};
            enb_r  <= {N_LEDS{1'b0}};
            done_r <= {N_LEDS{1'b0}};
        end else begin
            for (int i = 0; i < N_LEDS; i++) begin
                duty_r[i] <= duty_n[i];
                tgt_r[i]  <= tgt_n[i];
                step_r[i] <= step_n[i];
            end
            busy_r <= busy_n;
            enb_r  <= enb_n;
            done_r <= done_n;
        end
    end

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Bench for led_fade_ctrl: directed scenarios plus random commands, every
// cycle compared against a cycle-level arithmetic model of the fade rules.
module tb_led_fade_ctrl;

    localparam int N  = 4;
    localparam int BW = 8;
    localparam int TD = 16;

    logic          sysclk = 1'b0;
    logic          rst    = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_led = 2'd0;
    logic [7:0]    cmd_target = 8'd0;
    logic [7:0]    cmd_step = 8'd0;
    logic [31:0]   duty;
    logic [3:0]    enb, busy, done;
    logic          err;

    // Second instance with 3 channels so an out-of-range index is encodable.
    logic          v3 = 1'b0;
    logic          ready3;
    logic [1:0]    l3 = 2'd0;
    logic [7:0]    t3 = 8'd0;
    logic [7:0]    s3 = 8'd0;
    logic [23:0]   duty3;
    logic [2:0]    enb3, busy3, done3;
    logic          err3;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (register values visible in the current cycle).
    int       m_duty [N];
    int       m_tgt  [N];
    int       m_stp  [N];
    bit [3:0] m_busy, m_enb, m_done;
    bit       m_err;
    int       cyc;
    bit       last_acc;

    always #5 sysclk = ~sysclk;

    led_fade_ctrl #(.N_LEDS(N), .BRIGHTNESS_WIDTH(BW), .TICK_DIV(TD)) u_dut (
        .sysclk(sysclk), .rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_led(cmd_led), .i_cmd_target(cmd_target), .i_cmd_step(cmd_step),
        .o_duty(duty), .o_enb(enb), .o_busy(busy), .o_done(done), .o_err(err)
    );

    led_fade_ctrl #(.N_LEDS(3), .BRIGHTNESS_WIDTH(BW), .TICK_DIV(TD)) u_dut3 (
        .sysclk(sysclk), .rst(rst),
        .i_cmd_valid(v3), .o_cmd_ready(ready3),
        .i_cmd_led(l3), .i_cmd_target(t3), .i_cmd_step(s3),
        .o_duty(duty3), .o_enb(enb3), .o_busy(busy3), .o_done(done3), .o_err(err3)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_duty[i] = 0; m_tgt[i] = 0; m_stp[i] = 0;
        end
        m_busy = '0; m_enb = '0; m_done = '0; m_err = 1'b0;
        cyc = 0; last_acc = 1'b0;
    endtask

    // Called just after a posedge: asynchronous reset, immediate check, release.
    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        #2;
        check_val("rst_duty",  duty,      32'd0);
        check_val("rst_enb",   enb,       4'd0);
        check_val("rst_busy",  busy,      4'd0);
        check_val("rst_done",  done,      4'd0);
        check_val("rst_err",   err,       1'b0);
        check_val("rst_ready", cmd_ready, 1'b1);
        @(posedge sysclk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: compare outputs, advance model, step the DUT.
    task automatic run_cycle();
        int       n_duty [N];
        int       n_tgt  [N];
        int       n_stp  [N];
        bit [3:0] n_busy, n_enb, n_done;
        bit       n_err, acc, exp_ready;
        int       ch, d, t, s;
        logic [31:0] exp_duty;
        @(negedge sysclk);
        // A tick at phase TD-1 is followed by N scan cycles at phases 0..N-1.
        exp_ready = !(cyc >= TD && (cyc % TD) < N);
        for (int i = 0; i < N; i++) exp_duty[i*8 +: 8] = 8'(m_duty[i]);
        check_val("ready", cmd_ready, exp_ready);
        check_val("duty",  duty,      exp_duty);
        check_val("busy",  busy,      m_busy);
        check_val("enb",   enb,       m_enb);
        check_val("done",  done,      m_done);
        check_val("err",   err,       m_err);
        for (int i = 0; i < N; i++) begin
            n_duty[i] = m_duty[i]; n_tgt[i] = m_tgt[i]; n_stp[i] = m_stp[i];
        end
        n_busy = m_busy; n_done = '0; n_err = 1'b0;
        acc = cmd_valid && exp_ready;
        if (acc) begin
            if (int'(cmd_led) < N) begin
                n_tgt[cmd_led] = cmd_target;
                n_stp[cmd_led] = cmd_step;
                if (cmd_step == 8'd0) begin
                    n_duty[cmd_led] = cmd_target;
                    n_busy[cmd_led] = 1'b0;
                end else begin
                    n_busy[cmd_led] = (m_duty[cmd_led] != int'(cmd_target));
                end
            end else begin
                n_err = 1'b1;
            end
        end
        if (!exp_ready) begin
            ch = cyc % TD;
            d = m_duty[ch]; t = m_tgt[ch]; s = m_stp[ch];
            if (d != t) begin
                if (d < t) n_duty[ch] = (d + s >= t) ? t : d + s;
                else       n_duty[ch] = (d - s <= t) ? t : d - s;
                if (n_duty[ch] == t) begin
                    n_busy[ch] = 1'b0;
                    n_done[ch] = 1'b1;
                end
            end
        end
        for (int i = 0; i < N; i++) n_enb[i] = (n_duty[i] != 0) || m_busy[i];
        @(posedge sysclk); #1;
        for (int i = 0; i < N; i++) begin
            m_duty[i] = n_duty[i]; m_tgt[i] = n_tgt[i]; m_stp[i] = n_stp[i];
        end
        m_busy = n_busy; m_enb = n_enb; m_done = n_done; m_err = n_err;
        cyc++;
        last_acc = acc;
        if (acc) cmd_valid = 1'b0;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic send_cmd(input int led, input int tgt, input int stp);
        int k;
        cmd_led = 2'(led); cmd_target = 8'(tgt); cmd_step = 8'(stp);
        cmd_valid = 1'b1;
        k = 0;
        do begin
            run_cycle();
            k++;
        end while (!last_acc && k < 40);
        if (!last_acc) begin
            check_val("accept_timeout", 1'b0, 1'b1);
            cmd_valid = 1'b0;
        end
    endtask

    // Out-of-range index on the 3-channel instance: err pulse, state kept.
    initial begin
        @(negedge rst);
        l3 = 2'd0; t3 = 8'd77; s3 = 8'd0; v3 = 1'b1;
        @(posedge sysclk); #1;
        l3 = 2'd3; t3 = 8'd9; s3 = 8'd0;
        @(posedge sysclk); #1;
        v3 = 1'b0;
        @(negedge sysclk);
        check_val("bad_idx_err",  err3,  1'b1);
        check_val("bad_idx_duty", duty3, 24'd77);
        check_val("bad_idx_busy", busy3, 3'd0);
        @(negedge sysclk);
        check_val("bad_idx_err_1cyc", err3, 1'b0);
    end

    initial begin
        int k;
        model_reset();
        @(posedge sysclk); #1;
        do_reset();

        // Jump.
        send_cmd(2, 200, 0);
        run_n(1);
        check_val("jump_duty2", duty[23:16], 8'd200);

        // Fade up 0 -> 10 step 4.
        send_cmd(0, 10, 4);
        run_n(3 * TD + 4);
        check_val("fadeup_duty0", duty[7:0], 8'd10);

        // Fade down 255 -> 0 step 100.
        send_cmd(1, 255, 0);
        send_cmd(1, 0, 100);
        run_n(3 * TD + 6);
        check_val("fadedown_duty1", duty[15:8], 8'd0);
        check_val("fadedown_enb1",  enb[1],     1'b0);

        // Retarget mid-fade at duty 50.
        send_cmd(3, 200, 10);
        k = 0;
        while (m_duty[3] != 50 && k < 200) begin
            run_cycle();
            k++;
        end
        check_val("retarget_reach50", m_duty[3] == 50, 1'b1);
        send_cmd(3, 20, 10);
        run_n(4 * TD);
        check_val("retarget_duty3", duty[31:24], 8'd20);

        // Reset in the middle of a slow fade.
        send_cmd(0, 250, 1);
        run_n(40);
        do_reset();

        // Random commands, held until accepted.
        for (int i = 0; i < 1500; i++) begin
            if (!cmd_valid && $urandom_range(0, 5) == 0) begin
                cmd_led    = 2'($urandom_range(0, 3));
                cmd_target = 8'($urandom_range(0, 255));
                cmd_step   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 60));
                cmd_valid  = 1'b1;
            end
            run_cycle();
        end
        do_reset();
        run_n(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
